// File: rtl/fifo_stream_out.sv
// Prefetching read-side adapter: pulls words from a 1-cycle-latency FIFO into a
// 3-entry skid buffer and presents them as a valid/ready stream with a delivery count.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  fifo_mty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int DEPTH = 3;

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [DEPTH];

    logic       push;
    logic       pop;
    logic [1:0] wr_idx;
    logic [2:0] committed;

    // Slots already owned: buffered words plus the one whose data lands this cycle.
    // Only registered state feeds this, so m_ready never reaches fifo_rd.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd   = !fifo_mty && !srst && (committed < 3'd3);

    assign push = inflight_q;
    assign pop  = valid_q && m_ready;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        buf_d      = buf_q;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        inflight_d = fifo_rd;
        valid_d    = (occ_d != 2'd0);
        cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        wr_idx     = occ_q - {1'b0, pop};

        // Head lives in entry 0; a pop shifts everything down one slot.
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        if (push) begin
            buf_d[wr_idx] = fifo_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (srst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the data storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

    assign m_data   = buf_q[0];
    assign m_valid  = valid_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out: behavioural upstream FIFO, in-order scoreboard,
// and a CNT_WIDTH=4 twin instance for counter wrap.
module tb_fifo_stream_out;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          srst;
    logic          fifo_mty;
    logic          fifo_rd;
    logic          fifo_rd4;
    logic [DW-1:0] fifo_q;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_data4;
    logic          m_valid;
    logic          m_valid4;
    logic          m_ready;
    logic [15:0]   word_cnt;
    logic [3:0]    word_cnt4;

    fifo_stream_out #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .srst(srst), .fifo_mty(fifo_mty), .fifo_rd(fifo_rd), .fifo_q(fifo_q),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .word_cnt(word_cnt)
    );

    fifo_stream_out #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .srst(srst), .fifo_mty(fifo_mty), .fifo_rd(fifo_rd4), .fifo_q(fifo_q),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready), .word_cnt(word_cnt4)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    logic          force_mty   = 1'b0;
    int            outstanding = 0;
    int            cnt         = 0;
    int            rd_count    = 0;
    int            delivered   = 0;
    logic          stall_prev  = 1'b0;
    logic [DW-1:0] prev_data   = '0;
    logic          s_rd;
    logic          s_valid;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_mty();
        fifo_mty = (src_q.size() == 0) || force_mty;
    endtask

    // One clock: sample and check before the edge, then advance the upstream model.
    task automatic tick();
        logic          rd, hs, rst;
        logic [DW-1:0] w;
        @(negedge clk);
        rd      = fifo_rd;
        hs      = m_valid && m_ready;
        rst     = srst;
        s_rd    = rd;
        s_valid = m_valid;
        if (rst) begin
            check("rd_low_in_reset", {127'd0, rd}, '0);
        end else begin
            check("occ_inflight_le3", {127'd0, (outstanding <= 3)}, 1);
            check("word_cnt", {112'd0, word_cnt}, DW'(cnt[15:0]));
            check("word_cnt4", {124'd0, word_cnt4}, DW'(cnt[3:0]));
            if (rd) check("rd_needs_nonempty", {127'd0, fifo_mty}, '0);
            if (stall_prev) begin
                check("valid_held", {127'd0, m_valid}, 1);
                check("data_held", m_data, prev_data);
            end
            if (hs) begin
                check("word_expected", {127'd0, (exp_q.size() != 0)}, 1);
                if (exp_q.size() != 0) check("data_order", m_data, exp_q.pop_front());
                cnt++;
                delivered++;
            end
        end
        stall_prev = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #1;
        if (rst) begin
            outstanding = 0;
            cnt         = 0;
            exp_q.delete();
        end else begin
            if (hs) outstanding--;
            if (rd && src_q.size() != 0) begin
                w      = src_q.pop_front();
                fifo_q = w;
                exp_q.push_back(w);
                outstanding++;
                rd_count++;
            end
        end
        update_mty();
    endtask

    initial begin
        int first_rd, first_valid, last_valid, valid_run, base, hit;
        srst    = 1'b1;
        m_ready = 1'b0;
        fifo_q  = '0;
        update_mty();

        // Reset, then an empty upstream for 10 cycles.
        tick();
        tick();
        srst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_rd", {127'd0, s_rd}, '0);
            check("idle_valid", {127'd0, s_valid}, '0);
        end

        // 16 words at full rate: 2-cycle latency, 16 back-to-back valid cycles.
        for (int i = 1; i <= 16; i++) src_q.push_back(DW'(i));
        m_ready = 1'b1;
        update_mty();
        first_rd = -1; first_valid = -1; last_valid = -1; valid_run = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (s_rd && first_rd < 0) first_rd = c;
            if (s_valid) begin
                if (first_valid < 0) first_valid = c;
                last_valid = c;
                valid_run++;
            end
        end
        check("fill_latency", DW'(first_valid - first_rd), 2);
        check("valid_cycles", DW'(valid_run), 16);
        check("valid_contig", DW'(last_valid - first_valid), 15);
        check("cnt_after_16", {112'd0, word_cnt}, 16);

        // Stalled sink: exactly 3 reads, head held; then drain all 8 in order.
        m_ready = 1'b0;
        base    = rd_count;
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h100 + i));
        update_mty();
        for (int c = 0; c < 10; c++) tick();
        check("stall_reads", DW'(rd_count - base), 3);
        check("stall_valid", {127'd0, m_valid}, 1);
        check("stall_head", m_data, DW'(32'h100));
        m_ready = 1'b1;
        base    = delivered;
        for (int c = 0; c < 40 && (delivered - base) < 8; c++) tick();
        check("drain_count", DW'(delivered - base), 8);
        check("drain_empty", DW'(exp_q.size()), 0);

        // Reset with occ=2 and one read in flight; reads resume right after release.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) src_q.push_back(DW'(32'h200 + i));
        update_mty();
        for (int c = 0; c < 3; c++) tick();
        check("pre_rst_outstanding", DW'(outstanding), 3);
        check("pre_rst_valid", {127'd0, m_valid}, 1);
        src_q.push_back(DW'(32'h300));
        src_q.push_back(DW'(32'h301));
        update_mty();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        check("post_rst_valid", {127'd0, m_valid}, '0);
        check("post_rst_cnt", {112'd0, word_cnt}, '0);
        check("resume_rd", {127'd0, fifo_rd}, 1);
        for (int c = 0; c < 4; c++) tick();
        m_ready = 1'b1;
        base    = delivered;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("post_rst_words", DW'(delivered - base), 2);
        check("post_rst_cnt2", {112'd0, word_cnt}, 2);

        // 4-bit counter wrap over 17 handshakes.
        srst = 1'b1;
        tick();
        srst = 1'b0;
        for (int i = 0; i < 17; i++) src_q.push_back(DW'(32'h400 + i));
        update_mty();
        hit = 0;
        for (int c = 0; c < 40 && hit < 3; c++) begin
            tick();
            if (cnt == 15 && hit == 0) begin check("wrap_15", {124'd0, word_cnt4}, 4'hF); hit = 1; end
            if (cnt == 16 && hit == 1) begin check("wrap_16", {124'd0, word_cnt4}, 4'h0); hit = 2; end
            if (cnt == 17 && hit == 2) begin check("wrap_17", {124'd0, word_cnt4}, 4'h1); hit = 3; end
        end
        check("wrap_reached", DW'(hit), 3);

        // Random sink backpressure and upstream empty toggling.
        for (int c = 0; c < 10000; c++) begin
            force_mty = 1'($urandom_range(0, 1));
            m_ready   = 1'($urandom_range(0, 1));
            if (src_q.size() < 4 && $urandom_range(0, 3) != 0)
                src_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            update_mty();
            tick();
        end
        force_mty = 1'b0;
        m_ready   = 1'b1;
        update_mty();
        for (int c = 0; c < 60 && (exp_q.size() != 0 || src_q.size() != 0 || outstanding != 0); c++) tick();
        check("rand_drained", DW'(exp_q.size() + src_q.size()), 0);
        check("rand_outstanding", DW'(outstanding), 0);
        check("rand_cnt", {112'd0, word_cnt}, DW'(cnt[15:0]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port srst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fifo_mty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_rd  output  1  upstream FIFO read strobe.
REQ-007 SHALL have port fifo_q  input  DATA_WIDTH  upstream FIFO read data, valid exactly 1 cycle after fifo_rd.
REQ-008 SHALL have port m_data  output  DATA_WIDTH  stream data (buffer head).
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port word_cnt  output  CNT_WIDTH  count of words delivered (m_valid && m_ready).

Function
REQ-012 SHALL hold a 3-entry in-order buffer (occupancy occ, 0..3) plus a 1-bit in-flight flag inflight = fifo_rd of previous cycle.
REQ-013 SHALL drive fifo_rd = !fifo_mty && !srst && (occ + inflight < 3); no combinational path from m_ready to fifo_rd.
REQ-014 SHALL write fifo_q into the buffer tail in the cycle where inflight = 1; every issued read is captured, never dropped.
REQ-015 SHALL drive m_valid = (occ != 0) and m_data = buffer head, both from registers only.
REQ-016 SHALL pop the head on m_valid && m_ready; simultaneous capture and pop in one cycle leaves occ unchanged and preserves order.
REQ-017 SHALL keep m_data stable while m_valid && !m_ready (AXI-style: valid never retracted without handshake).
REQ-018 SHALL sustain one word per cycle when fifo_mty = 0 and m_ready = 1 continuously, after a 2-cycle fill latency (fifo_rd at cycle N -> m_valid at cycle N+2 earliest).
REQ-019 SHALL never exceed occ = 3; occ + inflight <= 3 invariant at all times.
REQ-020 SHALL ignore m_ready while m_valid = 0 (no pop, no count).
REQ-021 SHALL increment word_cnt by 1 per handshake, modulo 2**CNT_WIDTH (all-ones wraps to 0).
REQ-022 SHALL tolerate fifo_mty toggling every cycle; reads issued only when fifo_mty = 0 in that same cycle.

Reset
REQ-023 SHALL on srst = 1 clear occ to 0, inflight to 0, word_cnt to 0, m_valid to 0, at the next rising edge.
REQ-024 SHALL force fifo_rd = 0 combinationally while srst = 1.
REQ-025 SHALL discard buffer contents and any in-flight fifo_q when srst asserts mid-operation; m_data value after reset is don't-care but SHALL NOT be X-propagating into m_valid.
REQ-026 SHALL resume normal operation the first cycle after srst deasserts, with no extra idle cycles.

Verification
REQ-027 Reset then fifo_mty = 1 for 10 cycles -> fifo_rd = 0, m_valid = 0, word_cnt = 0 throughout.
REQ-028 FIFO preloaded with 0x1..0x10, m_ready = 1 -> m_data sequence 0x1..0x10 in order, 16 consecutive valid cycles after 2-cycle latency, word_cnt = 16.
REQ-029 FIFO with 8 words, m_ready = 0 -> exactly 3 fifo_rd pulses, occ = 3, m_data = first word held stable; then m_ready = 1 -> remaining 8 words delivered in order, no loss or duplication.
REQ-030 Random m_ready (50%) and random fifo_mty, 10,000 cycles -> scoreboard order match, occ + inflight <= 3 always, word_cnt equals handshake count.
REQ-031 srst asserted with occ = 2 and inflight = 1 -> next cycle m_valid = 0, word_cnt = 0, captured in-flight word not delivered.
REQ-032 CNT_WIDTH = 4, 17 handshakes -> word_cnt reads 0xF after 15, 0x0 after 16, 0x1 after 17.
